// File: rtl/rtc_time_counter.sv
// Time-of-day core: 1 Hz prescaler plus HH:MM:SS kept as six BCD digits.
// Optional alarm comparator is enabled by defining RTC_ALARM_EN.
module rtc_time_counter #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int PRESC_W = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        set_valid,
    input  logic [23:0] set_time,
`ifdef RTC_ALARM_EN
    input  logic        alarm_set_valid,
    input  logic [23:0] alarm_time,
    input  logic        alarm_en,
    output logic        alarm_hit,
`endif
    output logic        set_err,
    output logic        sec_tick,
    output logic [3:0]  h_tens,
    output logic [3:0]  h_ones,
    output logic [3:0]  m_tens,
    output logic [3:0]  m_ones,
    output logic [3:0]  s_tens,
    output logic [3:0]  s_ones
);

    // digit order matches set_time: [5]=h_tens ... [0]=s_ones
    typedef logic [5:0][3:0] tod_t;

    localparam logic [PRESC_W-1:0] PRESC_TC  = PRESC_W'(CLK_HZ - 1);
    localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);

    function automatic logic tod_ok(input tod_t t);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 6; i++)
            if (t[i] > 4'd9) ok = 1'b0;
        if (t[1] > 4'd5 || t[3] > 4'd5 || t[5] > 4'd2) ok = 1'b0;
        if (t[5] == 4'd2 && t[4] > 4'd3) ok = 1'b0;
        return ok;
    endfunction

    // Full ripple in one step so 23:59:59 rolls to 00:00:00 on a single edge.
    function automatic tod_t tod_inc(input tod_t t);
        tod_t n;
        n = t;
        if (t[0] != 4'd9) n[0] = t[0] + 4'd1;
        else begin
            n[0] = 4'd0;
            if (t[1] != 4'd5) n[1] = t[1] + 4'd1;
            else begin
                n[1] = 4'd0;
                if (t[2] != 4'd9) n[2] = t[2] + 4'd1;
                else begin
                    n[2] = 4'd0;
                    if (t[3] != 4'd5) n[3] = t[3] + 4'd1;
                    else begin
                        n[3] = 4'd0;
                        if (t[5] == 4'd2 && t[4] == 4'd3) begin
                            n[5] = 4'd0;
                            n[4] = 4'd0;
                        end else if (t[4] == 4'd9) begin
                            n[4] = 4'd0;
                            n[5] = t[5] + 4'd1;
                        end else begin
                            n[4] = t[4] + 4'd1;
                        end
                    end
                end
            end
        end
        return n;
    endfunction

    tod_t               tod;
    logic [PRESC_W-1:0] presc;
    logic               set_ok;
    logic               set_bad;
    logic               tc;

    assign set_ok  = set_valid && tod_ok(set_time);
    assign set_bad = set_valid && !tod_ok(set_time);
    assign tc      = run && (presc == PRESC_TC);

`ifdef RTC_ALARM_EN
    tod_t alarm_t;
    logic armed;
    logic alarm_ok;
    logic alarm_bad;

    assign alarm_ok  = alarm_set_valid && tod_ok(alarm_time);
    assign alarm_bad = alarm_set_valid && !tod_ok(alarm_time);

    // sec_tick marks a natural advance on the previous edge; loads never fire.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alarm_t   <= '0;
            armed     <= 1'b0;
            alarm_hit <= 1'b0;
        end else begin
            alarm_hit <= sec_tick && alarm_en && armed && (tod == alarm_t);
            if (alarm_ok) begin
                alarm_t <= alarm_time;
                armed   <= 1'b1;
            end
        end
    end
`else
    logic alarm_bad;
    assign alarm_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tod      <= '0;
            presc    <= '0;
            sec_tick <= 1'b0;
            set_err  <= 1'b0;
        end else begin
            sec_tick <= 1'b0;
            set_err  <= set_bad || alarm_bad;
            if (set_ok) begin
                // a valid load wins over a coincident terminal count
                tod   <= set_time;
                presc <= '0;
            end else if (run) begin
                if (tc) begin
                    presc    <= '0;
                    tod      <= tod_inc(tod);
                    sec_tick <= 1'b1;
                end else begin
                    presc <= presc + PRESC_ONE;
                end
            end
        end
    end

    assign h_tens = tod[5];
    assign h_ones = tod[4];
    assign m_tens = tod[3];
    assign m_ones = tod[2];
    assign s_tens = tod[1];
    assign s_ones = tod[0];

endmodule

// File: tb/tb_rtc_time_counter.sv
// Bench for rtc_time_counter: directed vector table, hand corner sequences,
// and randomized traffic against a seconds-of-day reference model.
module tb_rtc_time_counter;

    localparam int HZ = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        set_valid = 1'b0;
    logic [23:0] set_time = '0;
    logic        set_err, sec_tick;
    logic [3:0]  h_tens, h_ones, m_tens, m_ones, s_tens, s_ones;
    logic [23:0] dut_t;
`ifdef RTC_ALARM_EN
    logic        alarm_set_valid = 1'b0;
    logic [23:0] alarm_time = '0;
    logic        alarm_en = 1'b0;
    logic        alarm_hit;
`endif

    rtc_time_counter #(.CLK_HZ(HZ), .PRESC_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .set_valid(set_valid), .set_time(set_time),
`ifdef RTC_ALARM_EN
        .alarm_set_valid(alarm_set_valid), .alarm_time(alarm_time),
        .alarm_en(alarm_en), .alarm_hit(alarm_hit),
`endif
        .set_err(set_err), .sec_tick(sec_tick),
        .h_tens(h_tens), .h_ones(h_ones), .m_tens(m_tens),
        .m_ones(m_ones), .s_tens(s_tens), .s_ones(s_ones)
    );

    always #5 clk = ~clk;
    assign dut_t = {h_tens, h_ones, m_tens, m_ones, s_tens, s_ones};

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: seconds since midnight plus a cycle count within the second
    int   m_sod = 0;
    int   m_presc = 0;
    logic m_tick = 1'b0;
    logic m_err = 1'b0;

    typedef struct {
        logic        r, ru, sv;
        logic [23:0] st, et;
        logic        etick, eerr;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(logic r, logic ru, logic sv, logic [23:0] st,
                                logic [23:0] et, logic etick, logic eerr);
        vec_t v;
        v.r = r; v.ru = ru; v.sv = sv; v.st = st;
        v.et = et; v.etick = etick; v.eerr = eerr;
        tbl.push_back(v);
    endfunction

    function automatic logic [23:0] to_bcd(int sod);
        int h, m, s;
        h = sod / 3600; m = (sod / 60) % 60; s = sod % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic bit all_bcd(logic [23:0] t);
        bit ok;
        ok = 1;
        for (int i = 0; i < 6; i++) if (t[4*i +: 4] > 4'd9) ok = 0;
        return ok;
    endfunction

    function automatic bit legal(logic [23:0] t);
        int h, m, s;
        if (!all_bcd(t)) return 0;
        h = int'(t[23:20]) * 10 + int'(t[19:16]);
        m = int'(t[15:12]) * 10 + int'(t[11:8]);
        s = int'(t[7:4]) * 10 + int'(t[3:0]);
        return (h < 24) && (m < 60) && (s < 60);
    endfunction

    function automatic int from_bcd(logic [23:0] t);
        return (int'(t[23:20]) * 10 + int'(t[19:16])) * 3600 +
               (int'(t[15:12]) * 10 + int'(t[11:8])) * 60 +
               int'(t[7:4]) * 10 + int'(t[3:0]);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // one clock: drive, take the edge, settle, then advance the model
    task automatic step(input logic r, input logic ru, input logic sv, input logic [23:0] st);
        rst_n = r; run = ru; set_valid = sv; set_time = st;
        @(posedge clk);
        #1;
        m_tick = 1'b0;
        m_err  = 1'b0;
        if (!r) begin
            m_sod = 0; m_presc = 0;
        end else if (sv && legal(st)) begin
            m_sod = from_bcd(st); m_presc = 0;
        end else begin
            if (sv) m_err = 1'b1;
            if (ru) begin
                if (m_presc == HZ - 1) begin
                    m_presc = 0;
                    m_sod   = (m_sod + 1) % 86400;
                    m_tick  = 1'b1;
                end else begin
                    m_presc++;
                end
            end
        end
    endtask

    task automatic chk_model(string nm);
        chk(nm, {6'b0, sec_tick, set_err, dut_t}, {6'b0, m_tick, m_err, to_bcd(m_sod)});
    endtask

    initial begin
        int hits, hit_at;

        // directed table: one row per clock edge
        add(0, 1, 1, 24'h235958, 24'h000000, 0, 0);
        add(1, 1, 1, 24'h235958, 24'h235958, 0, 0);
        add(1, 1, 0, 24'h0,      24'h235958, 0, 0);
        add(1, 1, 0, 24'h0,      24'h235958, 0, 0);
        add(1, 1, 0, 24'h0,      24'h235958, 0, 0);
        add(1, 1, 0, 24'h0,      24'h235959, 1, 0);
        add(1, 1, 0, 24'h0,      24'h235959, 0, 0);
        add(1, 1, 0, 24'h0,      24'h235959, 0, 0);
        add(1, 1, 0, 24'h0,      24'h235959, 0, 0);
        add(1, 1, 0, 24'h0,      24'h000000, 1, 0);
        add(1, 1, 1, 24'h240000, 24'h000000, 0, 1);
        add(1, 1, 1, 24'h006000, 24'h000000, 0, 1);
        add(1, 1, 1, 24'h00000A, 24'h000000, 0, 1);
        add(1, 1, 1, 24'h123456, 24'h123456, 0, 0);
        add(1, 1, 0, 24'h0,      24'h123456, 0, 0);
        add(1, 1, 0, 24'h0,      24'h123456, 0, 0);
        add(1, 1, 0, 24'h0,      24'h123456, 0, 0);
        add(1, 1, 0, 24'h0,      24'h123457, 1, 0);
        add(1, 1, 0, 24'h0,      24'h123457, 0, 0);
        add(1, 1, 0, 24'h0,      24'h123457, 0, 0);
        add(1, 1, 0, 24'h0,      24'h123457, 0, 0);
        add(1, 1, 1, 24'h300000, 24'h123458, 1, 1);
        add(1, 0, 1, 24'h195959, 24'h195959, 0, 0);
        add(0, 1, 0, 24'h0,      24'h000000, 0, 0);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].ru, tbl[i].sv, tbl[i].st);
            chk($sformatf("vec%0d", i), {6'b0, sec_tick, set_err, dut_t},
                {6'b0, tbl[i].etick, tbl[i].eerr, tbl[i].et});
        end

        // 16 free-running cycles from reset: tick every 4th edge
        step(0, 0, 0, '0);
        for (int k = 1; k <= 16; k++) begin
            step(1, 1, 0, '0);
            chk($sformatf("run%0d", k), {7'b0, sec_tick, dut_t},
                {7'b0, (k % 4 == 0), to_bcd(k / 4)});
            chk($sformatf("bcd%0d", k), 32'(all_bcd(dut_t)), 32'd1);
        end

        // pause mid-second: partial count survives the pause
        step(0, 0, 0, '0);
        step(1, 1, 0, '0);
        step(1, 1, 0, '0);
        for (int k = 0; k < 10; k++) begin
            step(1, 0, 0, '0);
            chk($sformatf("pause%0d", k), {7'b0, sec_tick, dut_t}, 32'h0);
        end
        step(1, 1, 0, '0);
        chk("resume1", {7'b0, sec_tick, dut_t}, 32'h0);
        step(1, 1, 0, '0);
        chk("resume2", {7'b0, sec_tick, dut_t}, {7'b0, 1'b1, 24'h000001});

`ifdef RTC_ALARM_EN
        step(0, 0, 0, '0);
        alarm_time = 24'h000003; alarm_set_valid = 1'b1; alarm_en = 1'b1;
        step(1, 0, 0, '0);
        alarm_set_valid = 1'b0;
        hits = 0; hit_at = 0;
        for (int k = 1; k <= 20; k++) begin
            step(1, 1, 0, '0);
            if (alarm_hit) begin hits++; hit_at = k; end
        end
        chk("alarm_hits", 32'(hits), 32'd1);
        chk("alarm_at", 32'(hit_at), 32'd13);
        step(1, 0, 1, 24'h000003);
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 0, '0);
            chk($sformatf("alarm_noload%0d", k), 32'(alarm_hit), 32'd0);
        end
        alarm_time = 24'h990000; alarm_set_valid = 1'b1;
        step(1, 0, 0, '0);
        alarm_set_valid = 1'b0;
        chk("alarm_err", 32'(set_err), 32'd1);
        alarm_en = 1'b0;
`else
        hits = 0; hit_at = 0;
`endif

        // randomized traffic against the model
        step(0, 0, 0, '0);
        for (int k = 0; k < 3000; k++) begin
            logic        r, ru, sv;
            logic [23:0] st;
            r  = ($urandom_range(63) != 0);
            ru = ($urandom_range(3) != 0);
            sv = ($urandom_range(15) == 0);
            st = ($urandom_range(1) == 0) ? to_bcd(int'($urandom_range(86399))) : 24'($urandom);
            step(r, ru, sv, st);
            chk_model($sformatf("rnd%0d", k));
            if (!all_bcd(dut_t)) chk($sformatf("rnd_bcd%0d", k), {8'b0, dut_t}, 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
